// File: rtl/fifo_reader_if.sv
// fifo_reader_if -- bundles the signals between the fifo_reader, the
// upstream show-ahead FIFO and the downstream consumer.
//
// Signals
//   flush_en        discard everything buffered in the reader
//   fifo_empty      upstream FIFO has no entry
//   fifo_value      upstream FIFO head entry (valid while fifo_empty low)
//   fifo_dequeue_en reader pops the upstream head this cycle
//   out_valid       out_data holds a valid entry
//   out_data        head entry presented to the consumer
//   out_ready       consumer accepts out_data this cycle
//   xfer_count      completed output handshakes, modulo 2^16
//
// Modports
//   slave  : the reader itself
//   master : the environment (upstream FIFO + consumer + control)

interface fifo_reader_if #(
   parameter int WIDTH = 64
);
   logic             flush_en;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_value;
   logic             fifo_dequeue_en;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [15:0]      xfer_count;

   modport slave (
      input  flush_en,
      input  fifo_empty,
      input  fifo_value,
      input  out_ready,
      output fifo_dequeue_en,
      output out_valid,
      output out_data,
      output xfer_count
   );

   modport master (
      output flush_en,
      output fifo_empty,
      output fifo_value,
      output out_ready,
      input  fifo_dequeue_en,
      input  out_valid,
      input  out_data,
      input  xfer_count
   );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader -- pulls entries out of an upstream show-ahead FIFO into a
// two-entry registered buffer and presents them to a valid/ready consumer.
// slot0 drives the output, slot1 is a skid register that absorbs the one
// entry already dequeued when the consumer stalls. Because the dequeue
// decision only looks at the local occupancy, there is no combinational
// path from out_ready back to the upstream FIFO.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset
//   bus    : fifo_reader_if.slave (flush, upstream FIFO, consumer, count)
//
// States
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_EMPTY | no entry buffered, out_valid low
//   ST_ONE   | slot0 holds the head entry, slot1 unused
//   ST_FULL  | slot0 holds the head, slot1 holds the next entry;
//            | upstream dequeue is blocked

module fifo_reader #(
   parameter int WIDTH = 64
) (
   input  logic          clk,
   input  logic          reset,
   fifo_reader_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_slot0;
   logic [WIDTH-1:0] r_slot1;
   logic [15:0]      r_xfer_count;

   logic             w_deq;
   logic             w_pop;

   // Dequeue only depends on occupancy and upstream/flush/reset, never on
   // out_ready, so a stalled consumer cannot cause a dropped entry: the
   // skid slot is always free whenever a dequeue is issued.
   assign w_deq = !bus.fifo_empty && !bus.flush_en && !reset
                  && (r_state != ST_FULL);
   assign w_pop = r_out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_EMPTY;
         r_out_valid  <= 1'b0;
         r_slot0      <= '0;
         r_slot1      <= '0;
         r_xfer_count <= '0;
      end else begin
         // A handshake in the flush cycle still completed, so it is counted.
         if (w_pop) begin
            r_xfer_count <= r_xfer_count + 16'd1;
         end

         if (bus.flush_en) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
         end else begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_deq) begin
                     r_state     <= ST_ONE;
                     r_out_valid <= 1'b1;
                     r_slot0     <= bus.fifo_value;
                  end
               end
               ST_ONE: begin
                  if (w_deq && w_pop) begin
                     r_slot0 <= bus.fifo_value;
                  end else if (w_deq) begin
                     r_state <= ST_FULL;
                     r_slot1 <= bus.fifo_value;
                  end else if (w_pop) begin
                     r_state     <= ST_EMPTY;
                     r_out_valid <= 1'b0;
                  end
               end
               ST_FULL: begin
                  if (w_pop) begin
                     r_state <= ST_ONE;
                     r_slot0 <= r_slot1;
                  end
               end
               default: begin
                  r_state     <= ST_EMPTY;
                  r_out_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.fifo_dequeue_en = w_deq;
   assign bus.out_valid       = r_out_valid;
   assign bus.out_data        = r_slot0;
   assign bus.xfer_count      = r_xfer_count;

   a_no_deq_when_empty: assert property (
      @(posedge clk) !(bus.fifo_dequeue_en && bus.fifo_empty)
   );

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
   localparam int W = 64;

   logic clk = 1'b0;
   logic reset;

   fifo_reader_if #(.WIDTH(W)) bus ();

   fifo_reader #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_delivered = 0;
   bit chk_en = 1'b0;

   // upstream show-ahead FIFO contents and the reference buffer contents
   logic [W-1:0] up_q[$];
   logic [W-1:0] m_buf[$];
   logic [15:0]  m_count = 16'd0;
   bit           m_rst_zero = 1'b1;

   task automatic check(input string name, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // upstream FIFO pops whenever the reader dequeues a present entry
   always @(posedge clk) begin
      if (bus.fifo_dequeue_en === 1'b1 && bus.fifo_empty == 1'b0 && up_q.size() != 0)
         void'(up_q.pop_front());
   end

   // reference model: compare, then advance to the state after the next edge
   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_valid, exp_deq, pop;
         exp_valid = (m_buf.size() != 0);
         exp_deq   = !bus.fifo_empty && !bus.flush_en && !reset && (m_buf.size() < 2);
         check("out_valid", W'(bus.out_valid), W'(exp_valid));
         check("fifo_dequeue_en", W'(bus.fifo_dequeue_en), W'(exp_deq));
         check("xfer_count", W'(bus.xfer_count), W'(m_count));
         check("deq_when_empty", W'(bus.fifo_dequeue_en && bus.fifo_empty), '0);
         if (exp_valid)
            check("out_data", bus.out_data, m_buf[0]);
         else if (m_rst_zero)
            check("out_data_reset", bus.out_data, '0);

         pop = exp_valid && bus.out_ready;
         if (reset) begin
            m_buf.delete();
            m_count    = 16'd0;
            m_rst_zero = 1'b1;
         end else begin
            if (pop) begin
               m_count = m_count + 16'd1;
               n_delivered++;
            end
            if (bus.flush_en) begin
               m_buf.delete();
            end else begin
               if (pop) void'(m_buf.pop_front());
               if (exp_deq) begin
                  m_buf.push_back(bus.fifo_value);
                  m_rst_zero = 1'b0;
               end
            end
         end
      end
   end

   task automatic step(input bit f_empty, input bit rdy, input bit fl, input bit rst);
      @(posedge clk);
      #1;
      reset         = rst;
      bus.flush_en  = fl;
      bus.out_ready = rdy;
      if (f_empty || up_q.size() == 0) begin
         bus.fifo_empty = 1'b1;
         bus.fifo_value = {$urandom, $urandom};
      end else begin
         bus.fifo_empty = 1'b0;
         bus.fifo_value = up_q[0];
      end
   endtask

   task automatic drain(input int budget);
      int i;
      i = 0;
      while ((up_q.size() != 0 || m_buf.size() != 0) && i < budget) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         i++;
      end
      if (up_q.size() != 0 || m_buf.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got %0d entries left required 0",
                  up_q.size() + m_buf.size());
      end
   endtask

   initial begin
      logic [W-1:0] got[$];
      logic [15:0]  n_wrap;

      reset          = 1'b1;
      bus.flush_en   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_value = '0;

      // reset with entries waiting upstream: no dequeue while reset high
      up_q.push_back(64'hA);
      up_q.push_back(64'hB);
      up_q.push_back(64'hC);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_out_valid", W'(bus.out_valid), '0);
      check("rst_xfer_count", W'(bus.xfer_count), '0);
      check("rst_out_data", bus.out_data, '0);
      check("rst_deq", W'(bus.fifo_dequeue_en), '0);

      // A,B,C streamed with out_ready high
      step(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("abc_first_deq", W'(bus.fifo_dequeue_en), 1);
      check("abc_latency_valid", W'(bus.out_valid), 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("abc_data0", bus.out_data, 64'hA);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("abc_data1", bus.out_data, 64'hB);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("abc_data2", bus.out_data, 64'hC);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("abc_done_valid", W'(bus.out_valid), 0);
      check("abc_xfer_count", W'(bus.xfer_count), 3);

      // consumer stalled with 4 entries upstream: only 2 dequeued
      for (int i = 0; i < 4; i++) up_q.push_back(W'(64'h10 + i));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_full_deq", W'(bus.fifo_dequeue_en), 0);
      check("stall_full_upstream", W'(up_q.size()), 2);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_hold_data", bus.out_data, 64'h10);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         if (bus.out_valid) got.push_back(bus.out_data);
      end
      check("stall_delivered", W'(got.size()), 4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         check("stall_order", got[i], W'(64'h10 + i));
      check("stall_xfer_count", W'(bus.xfer_count), 7);

      // flush while FULL and stalled
      up_q.push_back(64'h20);
      up_q.push_back(64'h21);
      up_q.push_back(64'h22);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("flush_no_deq", W'(bus.fifo_dequeue_en), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("flush_out_valid", W'(bus.out_valid), 0);
      check("flush_xfer_count", W'(bus.xfer_count), 7);
      drain(50);

      // reset while FULL with upstream not empty
      for (int i = 0; i < 4; i++) up_q.push_back(W'(64'h30 + i));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("rfull_deq_in_reset", W'(bus.fifo_dequeue_en), 0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("rfull_out_valid", W'(bus.out_valid), 0);
      check("rfull_xfer_count", W'(bus.xfer_count), 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("rfull_deq_after_release", W'(bus.fifo_dequeue_en), 1);
      drain(50);

      // randomized traffic
      for (int i = 0; i < 10000; i++) begin
         while (up_q.size() < 3) up_q.push_back({$urandom, $urandom});
         step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0);
      drain(100);
      check("random_delivered_some", W'(n_delivered > 100), 1);

      // counter wrap: bring xfer_count to 0xFFFE, then 3 more transfers
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_wrap = 16'hFFFE - m_count;
      for (int i = 0; i < int'(n_wrap); i++) up_q.push_back({$urandom, $urandom});
      drain(70000);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("wrap_pre", W'(bus.xfer_count), 16'hFFFE);
      for (int i = 0; i < 3; i++) up_q.push_back(W'(64'h40 + i));
      drain(50);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("wrap_post", W'(bus.xfer_count), 16'h0001);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
